// File: rtl/pipe_sched.sv
// Pipeline sequencing controller: classifies the decoded opcode and drives the
// fetch/decode enables, ID/EX flush, stall lines and the load request handshake.
module pipe_sched #(
  parameter logic [5:0] LD_OP     = 6'b010100,
  parameter logic [5:0] JMP_OP    = 6'b011110,
  parameter logic [5:0] HLT_OP    = 6'b010001,
  parameter int         FLUSH_CYC = 2,
  parameter int         MAX_WAIT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       op_valid,
  input  logic       mem_ready,
  input  logic       resume,
  output logic       pc_en,
  output logic       if_id_en,
  output logic       id_ex_flush,
  output logic       stall,
  output logic       stall_pm,
  output logic       mem_req,
  output logic       halted,
  output logic       err,
  output logic [7:0] stall_cnt
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    FLUSH    = 3'd2,
    HALT     = 3'd3,
    ERR      = 3'd4
  } state_t;

  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [3:0] flush_q, flush_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_q      <= '0;
      flush_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      flush_q     <= flush_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    flush_d = flush_q;
    unique case (state_q)
      RUN: begin
        if (op_valid) begin
          if (op == LD_OP) begin
            state_d = MEM_WAIT;
            wait_d  = '0;
          end else if (op == JMP_OP) begin
            state_d = FLUSH;
            flush_d = FLUSH_INIT;
          end else if (op == HLT_OP) begin
            state_d = HALT;
          end
        end
      end
      MEM_WAIT: begin
        // A completing memory wins over a timeout on the same edge.
        if (mem_ready)              state_d = RUN;
        else if (wait_q == WAIT_LAST) state_d = ERR;
        else                        wait_d  = wait_q + 8'd1;
      end
      FLUSH: begin
        if (flush_q == 4'd0) state_d = RUN;
        else                 flush_d = flush_q - 4'd1;
      end
      HALT: begin
        if (resume) state_d = RUN;
      end
      ERR: state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  // Moore outputs: decoded from the registered state only.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_flush = 1'b0;
    stall       = 1'b0;
    stall_pm    = 1'b0;
    mem_req     = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    unique case (state_q)
      RUN: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
      MEM_WAIT: begin
        stall    = 1'b1;
        stall_pm = 1'b1;
        mem_req  = 1'b1;
      end
      FLUSH: begin
        id_ex_flush = 1'b1;
        stall_pm    = 1'b1;
      end
      HALT: begin
        stall    = 1'b1;
        stall_pm = 1'b1;
        halted   = 1'b1;
      end
      ERR: begin
        stall    = 1'b1;
        stall_pm = 1'b1;
        err      = 1'b1;
      end
      default: begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
      end
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall || stall_pm) && (stall_cnt_q != 8'hFF))
      stall_cnt_d = stall_cnt_q + 8'd1;
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sched.sv
// Bench for pipe_sched: directed scenarios plus random traffic, all compared
// against a cycle-level behavioural model of the sequencing rules.
module tb_pipe_sched;

  localparam logic [5:0] LD  = 6'b010100;
  localparam logic [5:0] JMP = 6'b011110;
  localparam logic [5:0] HLT = 6'b010001;
  localparam int FLUSH_CYC = 2;
  localparam int MAX_WAIT  = 8;

  localparam int M_RUN = 0, M_LOAD = 1, M_FLUSH = 2, M_HALT = 3, M_ERR = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic       op_valid = 1'b0;
  logic       mem_ready = 1'b0;
  logic       resume = 1'b0;
  logic       pc_en, if_id_en, id_ex_flush, stall, stall_pm, mem_req, halted, err;
  logic [7:0] stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  int m_mode = M_RUN;
  int m_age  = 0;
  int m_left = 0;
  int m_scnt = 0;

  pipe_sched #(
    .LD_OP(LD), .JMP_OP(JMP), .HLT_OP(HLT),
    .FLUSH_CYC(FLUSH_CYC), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset), .op(op), .op_valid(op_valid),
    .mem_ready(mem_ready), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_flush(id_ex_flush),
    .stall(stall), .stall_pm(stall_pm), .mem_req(mem_req),
    .halted(halted), .err(err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // {pc_en, if_id_en, id_ex_flush, stall, stall_pm, mem_req, halted, err}
  function automatic logic [7:0] exp_outs(input int mode);
    case (mode)
      M_LOAD:  return 8'b0001_1100;
      M_FLUSH: return 8'b0010_1000;
      M_HALT:  return 8'b0001_1010;
      M_ERR:   return 8'b0001_1001;
      default: return 8'b1100_0000;
    endcase
  endfunction

  // m_age counts load cycles spent so far, m_left the flush cycles still owed.
  task automatic model_edge();
    if (reset) begin
      m_mode = M_RUN; m_age = 0; m_left = 0; m_scnt = 0;
    end else begin
      if (m_mode != M_RUN && m_scnt < 255) m_scnt++;
      case (m_mode)
        M_RUN: if (op_valid) begin
          if (op == LD)       begin m_mode = M_LOAD;  m_age = 1; end
          else if (op == JMP) begin m_mode = M_FLUSH; m_left = FLUSH_CYC; end
          else if (op == HLT) m_mode = M_HALT;
        end
        M_LOAD: begin
          if (mem_ready)             m_mode = M_RUN;
          else if (m_age >= MAX_WAIT) m_mode = M_ERR;
          else                       m_age++;
        end
        M_FLUSH: begin
          m_left--;
          if (m_left == 0) m_mode = M_RUN;
        end
        M_HALT: if (resume) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("outs", {pc_en, if_id_en, id_ex_flush, stall, stall_pm, mem_req, halted, err},
          exp_outs(m_mode));
    check("stall_cnt", stall_cnt, m_scnt);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic issue(input logic [5:0] o);
    op = o; op_valid = 1'b1;
    step();
    op_valid = 1'b0; op = '0;
  endtask

  initial begin
    // Reset and idle
    reset = 1'b1;
    steps(2);
    reset = 1'b0;
    steps(5);
    check("idle_pc_en", pc_en, 1);
    check("idle_stall_cnt", stall_cnt, 0);

    // Load completing in the third wait cycle
    issue(LD);
    steps(2);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("load_done_pc_en", pc_en, 1);
    check("load_stall_cnt", stall_cnt, 3);

    // Load timeout, then ready/resume ignored in ERR
    issue(LD);
    steps(MAX_WAIT);
    check("timeout_err", err, 1);
    mem_ready = 1'b1; resume = 1'b1;
    steps(3);
    check("err_sticky", {err, pc_en}, 2'b10);
    mem_ready = 1'b0; resume = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;
    check("err_cleared", {err, pc_en}, 2'b01);

    // Ready arriving in the last allowed wait cycle
    issue(LD);
    steps(MAX_WAIT - 1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("last_cycle_ready", {err, pc_en}, 2'b01);

    // Jump flush with a load presented during the flush
    issue(JMP);
    op = LD; op_valid = 1'b1;
    check("flush_vis", {id_ex_flush, stall}, 2'b10);
    steps(FLUSH_CYC);
    op_valid = 1'b0; op = '0;
    check("flush_no_load", {mem_req, pc_en}, 2'b01);

    // Halt held long enough to saturate stall_cnt
    issue(HLT);
    steps(300);
    check("halt_halted", halted, 1);
    check("stall_cnt_sat", stall_cnt, 255);
    resume = 1'b1; step(); resume = 1'b0;
    check("resume_run", {halted, pc_en}, 2'b01);

    // Reset in the middle of a load, then a full-length timeout
    issue(LD);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    check("midreset_mem_req", {mem_req, pc_en}, 2'b01);
    issue(LD);
    steps(MAX_WAIT - 1);
    check("full_wait_no_err", {err, mem_req}, 2'b01);
    step();
    check("full_wait_err", err, 1);
    reset = 1'b1; step(); reset = 1'b0;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: op = LD;
        1: op = JMP;
        2: op = HLT;
        default: op = 6'($urandom);
      endcase
      op_valid  = ($urandom_range(0, 2) != 0);
      mem_ready = ($urandom_range(0, 5) == 0);
      resume    = ($urandom_range(0, 4) == 0);
      reset     = ($urandom_range(0, 79) == 0);
      step();
    end
    reset = 1'b0; op_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
